seg_display_scheduler: RTL and testbench

//   Shares the single 8-digit seven-segment display between N_REQ requesters.

---
 rtl/seg_display_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_seg_display_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scheduler.sv
// ---------------------------------------------------------------------------
// seg_display_scheduler
//
// Shares one 8-digit seven-segment display between N_REQ requesters. The
// display is granted round-robin. Each owner keeps it for HOLD_CYCLES cycles.
// A dark gap of BLANK_CYCLES cycles separates consecutive owners. The block
// drives the display's NUMBER and AN_MASK inputs directly.
//
// Optional feature (macro SEG_SCHED_PRIO0_EN):
//   When defined, requester 0 has high priority. It wins every arbitration
//   and preempts any other owner that is being shown.
//   When undefined, arbitration is pure round-robin with no preemption.
//
// Ports:
//   clk        in   system clock, rising edge
//   RESET_N    in   asynchronous active-low reset
//   REQ        in   [N_REQ]    level request per requester
//   REQ_NUMBER in   [32*N_REQ] 8 hex digits per requester
//   REQ_MASK   in   [8*N_REQ]  digit-off mask per requester
//   GRANT      out  [N_REQ]    one-hot current owner, 0 when none
//   OWNER      out  [3]        index of current/last owner
//   SWITCH     out  1-cycle pulse when GRANT gains a new owner
//   NUMBER     out  [32]       to display NUMBER
//   AN_MASK    out  [8]        to display AN_MASK, 8'hFF = all dark
// ---------------------------------------------------------------------------
module seg_display_scheduler #(
  parameter int N_REQ        = 4,
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int BLANK_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 RESET_N,
  input  logic [N_REQ-1:0]     REQ,
  input  logic [32*N_REQ-1:0]  REQ_NUMBER,
  input  logic [8*N_REQ-1:0]   REQ_MASK,
  output logic [N_REQ-1:0]     GRANT,
  output logic [2:0]           OWNER,
  output logic                 SWITCH,
  output logic [31:0]          NUMBER,
  output logic [7:0]           AN_MASK
);

  localparam int MAX_CYC = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]   blank_cnt;

  logic               found_hi;
  logic               found_lo;
  logic [2:0]         idx_hi;
  logic [2:0]         idx_lo;
  logic               arb_found;
  logic [2:0]         arb_idx;
  logic [N_REQ-1:0]   arb_onehot;
  logic [31:0]        arb_num;
  logic [7:0]         arb_mask;

  logic               owner_req;
  logic               others_req;
  logic               preempt;
  logic [31:0]        own_num;
  logic [7:0]         own_mask;

  // Round-robin winner search starting just above OWNER. The lowest
  // requester above OWNER wins. If there is none, the search wraps to the
  // lowest requester at or below OWNER. The loop runs downward, so the last
  // hit it records is the lowest index. The previous owner is searched last,
  // so it can only win again when it is the sole requester.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (REQ[i]) begin
        if (i > int'(OWNER)) begin
          found_hi = 1'b1;
          idx_hi   = 3'(i);
        end else begin
          found_lo = 1'b1;
          idx_lo   = 3'(i);
        end
      end
    end
    arb_found = found_hi | found_lo;
    arb_idx   = found_hi ? idx_hi : idx_lo;
`ifdef SEG_SCHED_PRIO0_EN
    if (REQ[0]) begin
      arb_idx = 3'd0;
    end
`endif
  end

  // Winner's one-hot code and its display data, loaded on entry to SHOW.
  always_comb begin
    arb_onehot = '0;
    arb_num    = '0;
    arb_mask   = 8'hFF;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == 3'(i)) begin
        arb_onehot[i] = 1'b1;
        arb_num       = REQ_NUMBER[32*i +: 32];
        arb_mask      = REQ_MASK[8*i +: 8];
      end
    end
  end

  // In SHOW, GRANT is the owner's one-hot code. It selects the owner's live
  // data and separates the owner's request from the other requests.
  always_comb begin
    owner_req  = |(REQ & GRANT);
    others_req = |(REQ & ~GRANT);
    own_num    = '0;
    own_mask   = 8'hFF;
    for (int i = 0; i < N_REQ; i++) begin
      if (GRANT[i]) begin
        own_num  = REQ_NUMBER[32*i +: 32];
        own_mask = REQ_MASK[8*i +: 8];
      end
    end
  end

`ifdef SEG_SCHED_PRIO0_EN
  assign preempt = REQ[0] & (OWNER != 3'd0);
`else
  assign preempt = 1'b0;
`endif

  // Scheduler FSM. All outputs are registered here.
  // In BLANK and IDLE, NUMBER keeps its last value while AN_MASK is dark.
  // When the dwell expires and the owner is the only requester, the hold
  // counter reloads in place. There is no gap and no SWITCH pulse.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      GRANT     <= '0;
      OWNER     <= 3'(N_REQ - 1);
      SWITCH    <= 1'b0;
      NUMBER    <= '0;
      AN_MASK   <= 8'hFF;
      hold_cnt  <= '0;
      blank_cnt <= '0;
    end else begin
      SWITCH <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_found) begin
            state    <= SHOW;
            GRANT    <= arb_onehot;
            OWNER    <= arb_idx;
            SWITCH   <= 1'b1;
            NUMBER   <= arb_num;
            AN_MASK  <= arb_mask;
            hold_cnt <= HOLD_LOAD;
          end else begin
            GRANT   <= '0;
            AN_MASK <= 8'hFF;
          end
        end
        SHOW: begin
          if (!owner_req || preempt || (hold_cnt == '0 && others_req)) begin
            state     <= BLANK;
            GRANT     <= '0;
            AN_MASK   <= 8'hFF;
            hold_cnt  <= '0;
            blank_cnt <= BLANK_LOAD;
          end else begin
            NUMBER   <= own_num;
            AN_MASK  <= own_mask;
            hold_cnt <= (hold_cnt == '0) ? HOLD_LOAD : hold_cnt - CNT_ONE;
          end
        end
        BLANK: begin
          if (blank_cnt != '0) begin
            blank_cnt <= blank_cnt - CNT_ONE;
          end else if (arb_found) begin
            state    <= SHOW;
            GRANT    <= arb_onehot;
            OWNER    <= arb_idx;
            SWITCH   <= 1'b1;
            NUMBER   <= arb_num;
            AN_MASK  <= arb_mask;
            hold_cnt <= HOLD_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          GRANT   <= '0;
          AN_MASK <= 8'hFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// ---------------------------------------------------------------------------
// tb_seg_display_scheduler
//
// Self-checking bench for seg_display_scheduler with N_REQ=4, HOLD_CYCLES=4
// and BLANK_CYCLES=2. The bench runs three parts:
//   - a round-robin vector table,
//   - hand-written sequences for reset, owner drop, drop at expiry and
//     priority,
//   - a randomized run checked against a phase/elapsed-count reference
//     model.
// ---------------------------------------------------------------------------
module tb_seg_display_scheduler;

  localparam int N_REQ = 4;
  localparam int HOLD  = 4;
  localparam int BLANK = 2;

  localparam logic [31:0] N0 = 32'h1234ABCD;
  localparam logic [31:0] N1 = 32'hCAFE0001;
  localparam logic [31:0] N2 = 32'hBEEF0002;
  localparam logic [31:0] N3 = 32'hDEAD0003;
  localparam logic [7:0]  M0 = 8'h0F;
  localparam logic [7:0]  M1 = 8'h3C;
  localparam logic [7:0]  M2 = 8'h55;
  localparam logic [7:0]  M3 = 8'hA0;

  localparam int P_IDLE = 0;
  localparam int P_SHOW = 1;
  localparam int P_GAP  = 2;

  logic                clk = 1'b0;
  logic                RESET_N;
  logic [N_REQ-1:0]    REQ;
  logic [32*N_REQ-1:0] REQ_NUMBER;
  logic [8*N_REQ-1:0]  REQ_MASK;
  logic [N_REQ-1:0]    GRANT;
  logic [2:0]          OWNER;
  logic                SWITCH;
  logic [31:0]         NUMBER;
  logic [7:0]          AN_MASK;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [2:0]  owner;
    logic        sw;
    logic [7:0]  an;
    logic [31:0] num;
  } vec_t;

  vec_t rr_tab[20];

  // Reference model: phase, owner, cycles shown in the current grant, and
  // cycles spent in the gap.
  int          m_phase;
  int          m_owner;
  int          m_elapsed;
  int          m_gapc;
  logic [31:0] m_number;
  logic [7:0]  m_mask;
  logic        m_switch;

  seg_display_scheduler #(
    .N_REQ        (N_REQ),
    .HOLD_CYCLES  (HOLD),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .RESET_N    (RESET_N),
    .REQ        (REQ),
    .REQ_NUMBER (REQ_NUMBER),
    .REQ_MASK   (REQ_MASK),
    .GRANT      (GRANT),
    .OWNER      (OWNER),
    .SWITCH     (SWITCH),
    .NUMBER     (NUMBER),
    .AN_MASK    (AN_MASK)
  );

  always #5 clk = ~clk;

  // Next owner: first request after 'last', wrapping around.
  function automatic int pick(input logic [3:0] req, input int last);
`ifdef SEG_SCHED_PRIO0_EN
    if (req[0]) return 0;
`endif
    for (int k = 1; k <= N_REQ; k++) begin
      if (((req >> ((last + k) % N_REQ)) & 4'd1) != 4'd0) return (last + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase   = P_IDLE;
    m_owner   = N_REQ - 1;
    m_elapsed = 0;
    m_gapc    = 0;
    m_number  = '0;
    m_mask    = 8'hFF;
    m_switch  = 1'b0;
  endtask

  task automatic model_grant(input int w);
    m_phase   = P_SHOW;
    m_owner   = w;
    m_elapsed = 0;
    m_switch  = 1'b1;
    m_number  = REQ_NUMBER[32*w +: 32];
    m_mask    = REQ_MASK[8*w +: 8];
  endtask

  task automatic model_step();
    int   w;
    logic owner_wants;
    logic others_want;
    logic preempt;
    logic expired;
    m_switch = 1'b0;
    if (m_phase == P_IDLE) begin
      w = pick(REQ, m_owner);
      if (w >= 0) model_grant(w);
    end else if (m_phase == P_SHOW) begin
      m_elapsed++;
      owner_wants = ((REQ >> m_owner) & 4'd1) != 4'd0;
      others_want = (REQ & ~(4'd1 << m_owner)) != 4'd0;
      preempt     = 1'b0;
`ifdef SEG_SCHED_PRIO0_EN
      preempt = REQ[0] && (m_owner != 0);
`endif
      expired = (m_elapsed % HOLD) == 0;
      if (!owner_wants || preempt || (expired && others_want)) begin
        m_phase = P_GAP;
        m_gapc  = 0;
      end else begin
        m_number = REQ_NUMBER[32*m_owner +: 32];
        m_mask   = REQ_MASK[8*m_owner +: 8];
      end
    end else begin
      m_gapc++;
      if (m_gapc == BLANK) begin
        w = pick(REQ, m_owner);
        if (w >= 0) model_grant(w);
        else m_phase = P_IDLE;
      end
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req);
    REQ = req;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] e_grant, input logic [2:0] e_owner,
                             input logic e_sw, input logic [7:0] e_an, input logic [31:0] e_num);
    vectors++;
    if ({GRANT, OWNER, SWITCH, AN_MASK, NUMBER} !== {e_grant, e_owner, e_sw, e_an, e_num}) begin
      miscompares++;
      $display("[TB] FAIL %s: got grant=%b owner=%0d switch=%b an_mask=%h number=%h, expected grant=%b owner=%0d switch=%b an_mask=%h number=%h",
               name, GRANT, OWNER, SWITCH, AN_MASK, NUMBER, e_grant, e_owner, e_sw, e_an, e_num);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, (m_phase == P_SHOW) ? (4'd1 << m_owner) : 4'd0, 3'(m_owner), m_switch,
                (m_phase == P_SHOW) ? m_mask : 8'hFF, m_number);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    model_reset();
    REQ = '0;
    @(posedge clk);
    #1;
    RESET_N = 1'b1;
  endtask

  initial begin
    logic [3:0]  rr_req;
    int          rr_own[4];
    logic [31:0] nums[4];
    logic [7:0]  masks[4];
    logic [3:0]  rq;
    int          r;
    int          lost;
    int          pulses;

    nums  = '{N0, N1, N2, N3};
    masks = '{M0, M1, M2, M3};

    // Round-robin table: each grant is 4 shown cycles followed by 2 dark
    // cycles. That gives a 6-cycle period starting at the first edge with
    // REQ applied.
`ifdef SEG_SCHED_PRIO0_EN
    rr_req = 4'b1110;
    rr_own = '{1, 2, 3, 1};
`else
    rr_req = 4'b1011;
    rr_own = '{0, 1, 3, 0};
`endif
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 6; c++) begin
        r = 6 * g + c;
        if (r < 20) begin
          rr_tab[r].req   = rr_req;
          rr_tab[r].owner = 3'(rr_own[g]);
          rr_tab[r].num   = nums[rr_own[g]];
          if (c < HOLD) begin
            rr_tab[r].grant = 4'd1 << rr_own[g];
            rr_tab[r].sw    = (c == 0);
            rr_tab[r].an    = masks[rr_own[g]];
          end else begin
            rr_tab[r].grant = 4'd0;
            rr_tab[r].sw    = 1'b0;
            rr_tab[r].an    = 8'hFF;
          end
        end
      end
    end

    RESET_N    = 1'b1;
    REQ        = '0;
    REQ_NUMBER = {N3, N2, N1, N0};
    REQ_MASK   = {M3, M2, M1, M0};
    model_reset();
    #2;
    RESET_N = 1'b0;
    #1;
    checkOutput("reset_values", 4'b0000, 3'd3, 1'b0, 8'hFF, 32'h0);
    @(posedge clk);
    #1;
    RESET_N = 1'b1;

    // Single requester: one grant, kept with no gap across dwell reloads.
    applyStimulus(4'b0001);
    checkOutput("single_first", 4'b0001, 3'd0, 1'b1, M0, N0);
    lost   = 0;
    pulses = SWITCH ? 1 : 0;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(4'b0001);
      if (GRANT !== 4'b0001) lost++;
      if (SWITCH) pulses++;
    end
    checkCount("single_no_blank", lost, 0);
    checkCount("single_switches", pulses, 1);
    checkOutput("single_hold", 4'b0001, 3'd0, 1'b0, M0, N0);

    // Asynchronous reset while owner 1 is showing.
    do_reset();
    applyStimulus(4'b0010);
    checkOutput("owner1_grant", 4'b0010, 3'd1, 1'b1, M1, N1);
    applyStimulus(4'b0010);
    checkOutput("owner1_show", 4'b0010, 3'd1, 1'b0, M1, N1);
    #2;
    RESET_N = 1'b0;
    model_reset();
    #1;
    checkOutput("reset_mid_show", 4'b0000, 3'd3, 1'b0, 8'hFF, 32'h0);
    REQ = '0;
    @(posedge clk);
    #1;
    RESET_N = 1'b1;

    // Round-robin table.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(rr_tab[i].req);
      checkOutput($sformatf("rr_row%0d", i), rr_tab[i].grant, rr_tab[i].owner, rr_tab[i].sw,
                  rr_tab[i].an, rr_tab[i].num);
    end

    // Owner drop after 2 shown cycles, then a drop with no other requester.
    do_reset();
    applyStimulus(4'b0010);
    applyStimulus(4'b0010);
    applyStimulus(4'b0100);
    checkOutput("drop_blank", 4'b0000, 3'd1, 1'b0, 8'hFF, N1);
    applyStimulus(4'b0100);
    checkOutput("drop_blank2", 4'b0000, 3'd1, 1'b0, 8'hFF, N1);
    applyStimulus(4'b0100);
    checkOutput("drop_next", 4'b0100, 3'd2, 1'b1, M2, N2);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);
    checkOutput("drop_idle", 4'b0000, 3'd2, 1'b0, 8'hFF, N2);
    applyStimulus(4'b0001);
    checkOutput("idle_regrant", 4'b0001, 3'd0, 1'b1, M0, N0);

    // Owner drop on the same cycle the dwell expires.
    do_reset();
    for (int i = 0; i < 4; i++) applyStimulus(4'b0001);
    checkOutput("expiry_last_show", 4'b0001, 3'd0, 1'b0, M0, N0);
    applyStimulus(4'b0100);
    checkOutput("expiry_drop_blank", 4'b0000, 3'd0, 1'b0, 8'hFF, N0);
    applyStimulus(4'b0100);
    applyStimulus(4'b0100);
    checkOutput("expiry_drop_next", 4'b0100, 3'd2, 1'b1, M2, N2);

    // Requester 0 rises while owner 2 is showing and requester 3 is waiting.
    do_reset();
    applyStimulus(4'b0100);
    checkOutput("prio_owner2", 4'b0100, 3'd2, 1'b1, M2, N2);
    applyStimulus(4'b0100);
    applyStimulus(4'b1101);
`ifdef SEG_SCHED_PRIO0_EN
    checkOutput("prio_preempt", 4'b0000, 3'd2, 1'b0, 8'hFF, N2);
    applyStimulus(4'b1101);
    applyStimulus(4'b1101);
    checkOutput("prio_grant0", 4'b0001, 3'd0, 1'b1, M0, N0);
`else
    checkOutput("rr_no_preempt", 4'b0100, 3'd2, 1'b0, M2, N2);
    applyStimulus(4'b1101);
    checkOutput("rr_owner2_done", 4'b0100, 3'd2, 1'b0, M2, N2);
    applyStimulus(4'b1101);
    checkOutput("rr_gap", 4'b0000, 3'd2, 1'b0, 8'hFF, N2);
    applyStimulus(4'b1101);
    applyStimulus(4'b1101);
    checkOutput("rr_grant3", 4'b1000, 3'd3, 1'b1, M3, N3);
`endif

    // Randomized run against the reference model, with live data changes
    // and occasional asynchronous resets.
    do_reset();
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2;
        RESET_N = 1'b0;
        model_reset();
        #1;
        checkModel("random_reset");
        @(posedge clk);
        #1;
        RESET_N = 1'b1;
      end else begin
        if ($urandom_range(0, 7) == 0) rq = 4'($urandom_range(0, 15));
        REQ_NUMBER = {$urandom, $urandom, $urandom, $urandom};
        REQ_MASK   = $urandom;
        applyStimulus(rq);
        checkModel("random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
